// File: rtl/stage_if_prefetch_pkg.sv
// Shared types for the instruction fetch stage with prefetch queue.
// Entry struct, fetch FSM states and the canonical NOP word.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DISCARD,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } q_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/stage_if_prefetch_if.sv
// Instruction-side Wishbone classic bus between fetch stage and memory.
// master = fetch stage, slave = memory / interconnect.
interface stage_if_prefetch_if;

  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_addr_o, wbm_dat_o, wbm_sel_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_addr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/stage_if_prefetch_queue.sv
// Synchronous FIFO for prefetched entries with flush.
// Push while full is accepted only together with a pop.
module if_queue #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign count_o = r_count;
  assign data_o  = r_mem[r_rptr];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// Fetch stage: Wishbone prefetcher feeding decode via a small queue.
// Define IF_ACCESS_FAULT_EN to turn bus errors into faulting entries.
module stage_if_prefetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR  = 32'h0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  stage_if_prefetch_if.master wb
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int NW = CW + 1;

  fetch_state_e   r_state;
  logic           r_cyc;
  logic [31:0]    r_fpc;
  logic [31:0]    r_adr;

  q_entry_t       w_entry;
  q_entry_t       w_head;
  logic [CW-1:0]  w_count;
  logic [NW-1:0]  w_next_cnt;
  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_slot;
  logic [31:0]    w_redir_pc;

  assign wb.wbm_addr_o = r_adr;
  assign wb.wbm_dat_o  = '0;
  assign wb.wbm_sel_o  = 4'hF;
  assign wb.wbm_we_o   = 1'b0;
  assign wb.wbm_cyc_o  = r_cyc;
  assign wb.wbm_stb_o  = r_cyc;

  assign w_redir_pc = align_pc(redirect_addr_i);
  assign w_pop      = !w_empty && instr_ready_i;

  always_comb begin
    w_push         = 1'b0;
    w_entry.pc     = r_fpc;
    w_entry.instr  = wb.wbm_dat_i;
    w_entry.fault  = 1'b0;
    if (r_state == BUSY && !redirect_i) begin
      if (wb.wbm_ack_i) begin
        w_push = 1'b1;
      end
`ifdef IF_ACCESS_FAULT_EN
      else if (wb.wbm_err_i) begin
        w_push        = 1'b1;
        w_entry.instr = NOP;
        w_entry.fault = 1'b1;
      end
`endif
    end
  end

  // room check includes this cycle's push/pop so a response always fits
  assign w_next_cnt = {1'b0, w_count} + NW'(w_push) - NW'(w_pop);
  assign w_slot     = w_next_cnt < NW'(QUEUE_DEPTH);

  if_queue #(
    .DEPTH (QUEUE_DEPTH),
    .T     (q_entry_t)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (w_push && (!w_full || w_pop)),
    .data_i  (w_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  assign instr_valid_o = !w_empty;
  assign instruction_o = w_empty ? NOP : w_head.instr;
  assign pc_o          = w_empty ? '0 : w_head.pc;

`ifdef IF_ACCESS_FAULT_EN
  assign fault_o = !w_empty && w_head.fault;
`else
  logic w_unused_fault;
  assign w_unused_fault = w_head.fault;
  assign fault_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cyc   <= 1'b0;
      r_fpc   <= RESET_ADDR;
      r_adr   <= RESET_ADDR;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (redirect_i) begin
            r_fpc <= w_redir_pc;
          end else if (w_slot) begin
            r_cyc   <= 1'b1;
            r_adr   <= r_fpc;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (redirect_i) begin
            r_fpc <= w_redir_pc;
            if (wb.wbm_ack_i || wb.wbm_err_i) begin
              r_cyc   <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_state <= DISCARD;
            end
          end else if (wb.wbm_ack_i) begin
            r_fpc <= r_fpc + 32'd4;
            if (w_slot) begin
              r_adr <= r_fpc + 32'd4;
            end else begin
              r_cyc   <= 1'b0;
              r_state <= IDLE;
            end
          end else if (wb.wbm_err_i) begin
            r_cyc <= 1'b0;
`ifdef IF_ACCESS_FAULT_EN
            r_state <= HALT;
`else
            r_state <= IDLE;
`endif
          end
        end
        DISCARD: begin
          if (redirect_i) r_fpc <= w_redir_pc;
          if (wb.wbm_ack_i || wb.wbm_err_i) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end
        end
`ifdef IF_ACCESS_FAULT_EN
        HALT: begin
          if (redirect_i) begin
            r_fpc   <= w_redir_pc;
            r_state <= IDLE;
          end
        end
`endif
        default: begin
          r_cyc   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
